// File: rtl/ysyx_23060203_pkg.sv
// Shared core constants: register address width and architectural register
// counts for the RV32I and RV32E profiles.
package ysyx_23060203_pkg;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_SLOTS    = 1 << REG_ADDR_W;
    localparam int NR_REG_RV32I = 32;
    localparam int NR_REG_RV32E = 16;
endpackage

// File: rtl/regfile_sb_if.sv
// Issue/read/writeback bundle between the pipeline (master) and the
// scoreboarded register file (slave).
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NR_RD = 2
);
    import ysyx_23060203_pkg::*;

    logic [REG_ADDR_W*NR_RD-1:0] raddr;
    logic [XLEN*NR_RD-1:0]       rdata;
    logic [NR_RD-1:0]            rbusy;
    logic [NR_RD-1:0]            rbad;
    logic                        issue_valid;
    logic [REG_ADDR_W-1:0]       issue_rd;
    logic                        issue_ready;
    logic                        wb_en;
    logic [REG_ADDR_W-1:0]       wb_addr;
    logic [XLEN-1:0]             wb_data;
    logic                        flush;

    modport master (
        output raddr, issue_valid, issue_rd, wb_en, wb_addr, wb_data, flush,
        input  rdata, rbusy, rbad, issue_ready
    );

    modport slave (
        input  raddr, issue_valid, issue_rd, wb_en, wb_addr, wb_data, flush,
        output rdata, rbusy, rbad, issue_ready
    );
endinterface

// File: rtl/regfile_sb_cnt.sv
// Saturating up/down counter of in-flight writes for one register.
// Simultaneous inc and dec cancel; clr wins over both.
module regfile_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending-write counters,
// same-cycle writeback bypass and flush for the pipelined core.
module regfile_sb
    import ysyx_23060203_pkg::*;
#(
    parameter int NR_REG = 32,
    parameter int XLEN   = 32,
    parameter int NR_RD  = 2,
    parameter int CNT_W  = 2
) (
    input  logic         clk,
    input  logic         rstn,
    regfile_sb_if.slave  bus
);
    typedef logic [REG_ADDR_W-1:0] addr_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic addr_ok(input addr_t a);
        return int'(a) < NR_REG;
    endfunction

    function automatic logic addr_wr(input addr_t a);
        return addr_ok(a) && (a != '0);
    endfunction

    // Storage spans the full address space; slots 0 and >= NR_REG are never written.
    logic [XLEN-1:0]  rf_d [REG_SLOTS];
    logic [XLEN-1:0]  rf_q [REG_SLOTS];
    logic [CNT_W-1:0] cnt  [REG_SLOTS];
    logic             rel;
    logic             fire;
    logic             issue_ready;

    assign rel = bus.wb_en && addr_wr(bus.wb_addr);

    always_comb begin
        rf_d = rf_q;
        if (rel) begin
            rf_d[bus.wb_addr] = bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    // A full counter can still take a reservation when the same register retires this cycle.
    assign issue_ready = (cnt[bus.issue_rd] != CNT_MAX) || (rel && bus.wb_addr == bus.issue_rd);
    assign bus.issue_ready = issue_ready;
    assign fire = bus.issue_valid && issue_ready && addr_wr(bus.issue_rd);

    for (genvar i = 0; i < REG_SLOTS; i++) begin : g_cnt
        if (i > 0 && i < NR_REG) begin : g_live
            regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk  (clk),
                .rstn (rstn),
                .inc  (fire && bus.issue_rd == addr_t'(i)),
                .dec  (rel && bus.wb_addr == addr_t'(i)),
                .clr  (bus.flush),
                .cnt  (cnt[i])
            );
        end else begin : g_tie
            assign cnt[i] = '0;
        end
    end

    // Sources are read against pre-issue counters; a hit consumes one pending write.
    for (genvar p = 0; p < NR_RD; p++) begin : g_rd
        addr_t a;
        logic  hit;

        assign a   = bus.raddr[REG_ADDR_W*p +: REG_ADDR_W];
        assign hit = rel && (bus.wb_addr == a);

        assign bus.rdata[XLEN*p +: XLEN] = (!rstn || !addr_wr(a)) ? '0 :
                                           hit ? bus.wb_data : rf_q[a];
        assign bus.rbusy[p] = addr_wr(a) && (hit ? (cnt[a] > CNT_W'(1)) : (cnt[a] != '0));
        assign bus.rbad[p]  = !addr_ok(a);
    end
endmodule
